pc_unit: RTL and testbench

//   16-bit program counter (PCL/PCH) with its incrementer. It is the upstream source of the

---
 rtl/pc_unit.sv | 85 ++++++++
 tb/tb_pc_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: 16-bit program counter (PCL/PCH) with incrementer and bus drivers.
// Each rising phi1 edge performs three steps:
//   - select the current PC half or the ADL/ADH bus value for each half;
//   - optionally add one across the full 16 bits;
//   - store the result.
// The stored PC is presented to the ADL/ADH/DB buses under the drive enables.
module pc_unit #(
    parameter logic [7:0] RESET_PCL = 8'hFC,
    parameter logic [7:0] RESET_PCH = 8'hFF
) (
    input  logic        phi1,
    input  logic        reset,
    input  logic        pcl_load_EN,
    input  logic        pch_load_EN,
    input  logic        increment_EN,
    input  logic        pcl_drive_adl_EN,
    input  logic        pch_drive_adh_EN,
    input  logic        pcl_drive_db_EN,
    input  logic        pch_drive_db_EN,
    input  logic [7:0]  addressLowBus_IN,
    input  logic [7:0]  addressHighBus_IN,
    output logic [7:0]  addressLowBus_OUT,
    output logic [7:0]  addressHighBus_OUT,
    output logic        adl_drive_OUT,
    output logic        adh_drive_OUT,
    output logic [7:0]  dataBus_OUT,
    output logic        db_drive_OUT,
    output logic [15:0] pc_OUT,
    output logic        page_cross_OUT
);

    logic [7:0]  pcl_q;
    logic [7:0]  pch_q;
    logic        page_cross_q;
    logic [7:0]  src_l;
    logic [7:0]  src_h;
    logic [15:0] pc_d;
    logic        page_cross_d;

    // Source selection and optional increment of the selected {PCH,PCL}
    always_comb begin
        src_l        = pcl_load_EN ? addressLowBus_IN  : pcl_q;
        src_h        = pch_load_EN ? addressHighBus_IN : pch_q;
        pc_d         = {src_h, src_l};
        page_cross_d = 1'b0;
        if (increment_EN) begin
            pc_d         = {src_h, src_l} + 16'd1;
            page_cross_d = (src_l == 8'hFF);
        end
    end

    // PC and page-cross state; reset overrides every enable
    always_ff @(posedge phi1) begin
        if (reset) begin
            pcl_q        <= RESET_PCL;
            pch_q        <= RESET_PCH;
            page_cross_q <= 1'b0;
        end else begin
            pcl_q        <= pc_d[7:0];
            pch_q        <= pc_d[15:8];
            page_cross_q <= page_cross_d;
        end
    end

    // Bus presentation: combinational from the registered PC and drive enables.
    // PCL has priority on the data bus if both halves are requested.
    always_comb begin
        addressLowBus_OUT  = pcl_drive_adl_EN ? pcl_q : '0;
        addressHighBus_OUT = pch_drive_adh_EN ? pch_q : '0;
        if (pcl_drive_db_EN) begin
            dataBus_OUT = pcl_q;
        end else if (pch_drive_db_EN) begin
            dataBus_OUT = pch_q;
        end else begin
            dataBus_OUT = '0;
        end
    end

    assign adl_drive_OUT  = pcl_drive_adl_EN;
    assign adh_drive_OUT  = pch_drive_adh_EN;
    assign db_drive_OUT   = pcl_drive_db_EN | pch_drive_db_EN;
    assign pc_OUT         = {pch_q, pcl_q};
    assign page_cross_OUT = page_cross_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed, table-driven checks of the program counter unit.
module tb_pc_unit;

    logic        phi1 = 1'b0;
    logic        reset;
    logic        pcl_load_EN, pch_load_EN, increment_EN;
    logic        pcl_drive_adl_EN, pch_drive_adh_EN, pcl_drive_db_EN, pch_drive_db_EN;
    logic [7:0]  addressLowBus_IN, addressHighBus_IN;
    logic [7:0]  addressLowBus_OUT, addressHighBus_OUT, dataBus_OUT;
    logic        adl_drive_OUT, adh_drive_OUT, db_drive_OUT;
    logic [15:0] pc_OUT;
    logic        page_cross_OUT;

    int unsigned tests = 0;
    int unsigned fails = 0;

    pc_unit #(.RESET_PCL(8'hFC), .RESET_PCH(8'hFF)) dut (
        .phi1               (phi1),
        .reset              (reset),
        .pcl_load_EN        (pcl_load_EN),
        .pch_load_EN        (pch_load_EN),
        .increment_EN       (increment_EN),
        .pcl_drive_adl_EN   (pcl_drive_adl_EN),
        .pch_drive_adh_EN   (pch_drive_adh_EN),
        .pcl_drive_db_EN    (pcl_drive_db_EN),
        .pch_drive_db_EN    (pch_drive_db_EN),
        .addressLowBus_IN   (addressLowBus_IN),
        .addressHighBus_IN  (addressHighBus_IN),
        .addressLowBus_OUT  (addressLowBus_OUT),
        .addressHighBus_OUT (addressHighBus_OUT),
        .adl_drive_OUT      (adl_drive_OUT),
        .adh_drive_OUT      (adh_drive_OUT),
        .dataBus_OUT        (dataBus_OUT),
        .db_drive_OUT       (db_drive_OUT),
        .pc_OUT             (pc_OUT),
        .page_cross_OUT     (page_cross_OUT)
    );

    always #5 phi1 = ~phi1;

    typedef struct {
        logic        rst;
        logic        ld_l;
        logic        ld_h;
        logic        inc;
        logic        d_adl;
        logic        d_adh;
        logic        d_ldb;
        logic        d_hdb;
        logic [7:0]  adl;
        logic [7:0]  adh;
        logic [15:0] exp_pc;
        logic        exp_pcx;
        logic [7:0]  exp_adl;
        logic [7:0]  exp_adh;
        logic [7:0]  exp_db;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset             = v.rst;
        pcl_load_EN       = v.ld_l;
        pch_load_EN       = v.ld_h;
        increment_EN      = v.inc;
        pcl_drive_adl_EN  = v.d_adl;
        pch_drive_adh_EN  = v.d_adh;
        pcl_drive_db_EN   = v.d_ldb;
        pch_drive_db_EN   = v.d_hdb;
        addressLowBus_IN  = v.adl;
        addressHighBus_IN = v.adh;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".pc"},      pc_OUT,                    v.exp_pc);
        check({tag, ".pcx"},     {15'd0, page_cross_OUT},   {15'd0, v.exp_pcx});
        check({tag, ".adl_out"}, {8'd0, addressLowBus_OUT}, {8'd0, v.exp_adl});
        check({tag, ".adh_out"}, {8'd0, addressHighBus_OUT},{8'd0, v.exp_adh});
        check({tag, ".db_out"},  {8'd0, dataBus_OUT},       {8'd0, v.exp_db});
        check({tag, ".adl_drv"}, {15'd0, adl_drive_OUT},    {15'd0, v.d_adl});
        check({tag, ".adh_drv"}, {15'd0, adh_drive_OUT},    {15'd0, v.d_adh});
        check({tag, ".db_drv"},  {15'd0, db_drive_OUT},     {15'd0, v.d_ldb | v.d_hdb});
    endtask

    task automatic step_check(input string tag, input vec_t v);
        if (v.d_ldb && v.d_hdb)
            $display("[TB] protocol error in %s: both data-bus drive enables asserted", tag);
        drive(v);
        @(posedge phi1);
        #1;
        check_all(tag, v);
    endtask

    vec_t h;

    initial begin
        //          rst ld_l ld_h inc adl adh ldb hdb  ADL    ADH    PC        pcx  adlO   adhO   db
        vecs[0]  = '{1, 0, 0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 16'hFFFC, 0, 8'hFC, 8'hFF, 8'h00};
        vecs[1]  = '{0, 1, 1, 0, 0, 0, 0, 0, 8'hFF, 8'h00, 16'h00FF, 0, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0100, 1, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0100, 0, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{0, 1, 1, 1, 0, 0, 0, 0, 8'h34, 8'h12, 16'h1235, 0, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{0, 1, 1, 0, 0, 0, 0, 0, 8'hFF, 8'hFF, 16'hFFFF, 0, 8'h00, 8'h00, 8'h00};
        vecs[6]  = '{0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{0, 1, 1, 0, 0, 0, 0, 0, 8'hCD, 8'hAB, 16'hABCD, 0, 8'h00, 8'h00, 8'h00};
        vecs[8]  = '{0, 0, 0, 0, 1, 0, 0, 1, 8'h00, 8'h00, 16'hABCD, 0, 8'hCD, 8'h00, 8'hAB};
        vecs[9]  = '{0, 0, 1, 1, 0, 0, 0, 0, 8'h55, 8'h12, 16'h12CE, 0, 8'h00, 8'h00, 8'h00};
        vecs[10] = '{0, 1, 0, 1, 0, 0, 0, 0, 8'hFF, 8'h99, 16'h1300, 1, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{0, 1, 0, 0, 0, 0, 1, 1, 8'h77, 8'h00, 16'h1377, 0, 8'h00, 8'h00, 8'h77};
        vecs[12] = '{0, 0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 16'h1377, 0, 8'h00, 8'h13, 8'h13};

        h = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 0, 8'h00, 8'h00, 8'h00};
        drive(h);
        #2;

        for (int i = 0; i < NV; i++)
            step_check($sformatf("v%0d", i), vecs[i]);

        // Drive outputs respond in the same cycle without an edge; PC must not move.
        h = '{0, 1, 1, 0, 0, 0, 0, 0, 8'hCD, 8'hAB, 16'hABCD, 0, 8'h00, 8'h00, 8'h00};
        step_check("ld_abcd", h);
        @(negedge phi1);
        h = '{0, 0, 0, 0, 1, 0, 0, 1, 8'h00, 8'h00, 16'hABCD, 0, 8'hCD, 8'h00, 8'hAB};
        drive(h);
        #1;
        check_all("comb_drv", h);

        // Reset in the middle of a load/increment sequence wins, then increments from the vector.
        h = '{0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h20, 16'h2000, 0, 8'h00, 8'h00, 8'h00};
        step_check("ld_2000", h);
        h = '{1, 1, 1, 1, 0, 0, 0, 0, 8'h00, 8'h20, 16'hFFFC, 0, 8'h00, 8'h00, 8'h00};
        step_check("rst_mid", h);
        h = '{0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h20, 16'hFFFD, 0, 8'h00, 8'h00, 8'h00};
        step_check("inc_after_rst", h);
        h = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'hFFFD, 0, 8'h00, 8'h00, 8'h00};
        step_check("hold", h);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
